iterative_shift_controller: RTL

- Multi-cycle shift sequencer for the CPU datapath.
- Performs a variable-amount shift (SLL, SRL, SRA or ROTL) by applying a fixed shift-by-2 step repeatedly, with a final shift-by-1 step when the amount is odd.
- Serves shift instructions and any consumer that needs variable shifts without a full barrel shifter.
- Start/Busy/Done handshake towards the control unit.

---
 rtl/iterative_shift_controller.sv | 104 ++++++++++
 1 files changed

// File: rtl/iterative_shift_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iterative_shift_controller: variable shift (SLL/SRL/SRA/ROTL) built from
// repeated shift-by-2 steps plus a final shift-by-1 for odd amounts.
// Rev 1.0
// ---------------------------------------------------------------------------
module iterative_shift_controller #(
  parameter int DATA_SIZE = 32,
  parameter int SHAMT_W   = 5
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [SHAMT_W-1:0]   shamt_i,
  input  logic [DATA_SIZE-1:0] in_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DATA_SIZE-1:0] out_o
);

  localparam int MSB = DATA_SIZE - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               state_q;
  logic [DATA_SIZE-1:0] acc_q;
  logic [SHAMT_W-1:0]   rem_q;
  logic [1:0]           op_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 step2_d;
  logic [DATA_SIZE-1:0] acc_d;
  logic [SHAMT_W-1:0]   rem_d;

  // One step of the sequencer: shift by 2 while at least 2 remain, else by 1.
  always_comb begin
    step2_d = (rem_q >= SHAMT_W'(2));
    rem_d   = rem_q - (step2_d ? SHAMT_W'(2) : SHAMT_W'(1));
    case (op_q)
      2'b00:   acc_d = step2_d ? {acc_q[MSB-2:0], 2'b00} : {acc_q[MSB-1:0], 1'b0};
      2'b01:   acc_d = step2_d ? {2'b00, acc_q[MSB:2]}   : {1'b0, acc_q[MSB:1]};
      2'b10:   acc_d = step2_d ? {{2{acc_q[MSB]}}, acc_q[MSB:2]}
                               : {acc_q[MSB], acc_q[MSB:1]};
      default: acc_d = step2_d ? {acc_q[MSB-2:0], acc_q[MSB:MSB-1]}
                               : {acc_q[MSB-1:0], acc_q[MSB]};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          if (rem_d == '0) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
          if (start_i) begin
            acc_q <= in_i;
            rem_q <= shamt_i;
            op_q  <= op_i;
            if (shamt_i != '0) begin
              state_q <= ST_SHIFT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign out_o  = acc_q;

endmodule
`default_nettype wire
